// File: rtl/patch_pkg.sv
// patch_pkg: FSM state encoding and sizing helpers for the patch extractor.
// Pure definitions, no timing or flow control.
package patch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COPY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int num_tokens(input int img_h, input int img_w, input int patch);
      return (img_h / patch) * (img_w / patch);
   endfunction

   function automatic int patch_dim(input int patch, input int ch);
      return patch * patch * ch;
   endfunction

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int pix_index(input int y, input int x, input int c,
                                    input int img_w, input int ch);
      return (y * img_w + x) * ch + c;
   endfunction

endpackage

// File: rtl/patch_addr_gen.sv
// patch_addr_gen: nested c/px/py/pc/pr counters mapping stream position to token, element and pixel.
// Outputs are combinational from the counters; holding advance low freezes everything.
module patch_addr_gen
   import patch_pkg::*;
#(
   parameter  int IMG_H      = 56,
   parameter  int IMG_W      = 56,
   parameter  int C          = 3,
   parameter  int PATCH      = 4,
   localparam int NUM_TOKENS = num_tokens(IMG_H, IMG_W, PATCH),
   localparam int PATCH_DIM  = patch_dim(PATCH, C),
   localparam int T_W        = cnt_width(NUM_TOKENS),
   localparam int K_W        = cnt_width(PATCH_DIM),
   localparam int PIX_W      = cnt_width(IMG_H * IMG_W * C)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   output logic [T_W-1:0]   t,
   output logic [K_W-1:0]   k,
   output logic [PIX_W-1:0] pix_idx,
   output logic             last_elem
);

   localparam int ROWS = IMG_H / PATCH;
   localparam int COLS = IMG_W / PATCH;
   localparam int C_W  = cnt_width(C);
   localparam int P_W  = cnt_width(PATCH);
   localparam int PC_W = cnt_width(COLS);
   localparam int PR_W = cnt_width(ROWS);

   logic [C_W-1:0]  c_q,  c_d;
   logic [P_W-1:0]  px_q, px_d;
   logic [P_W-1:0]  py_q, py_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PR_W-1:0] pr_q, pr_d;

   always_comb begin
      c_d  = c_q;
      px_d = px_q;
      py_d = py_q;
      pc_d = pc_q;
      pr_d = pr_q;
      if (clear) begin
         c_d  = '0;
         px_d = '0;
         py_d = '0;
         pc_d = '0;
         pr_d = '0;
      end else if (advance) begin
         c_d = c_q + C_W'(1);
         if (c_q == C_W'(C - 1)) begin
            c_d  = '0;
            px_d = px_q + P_W'(1);
            if (px_q == P_W'(PATCH - 1)) begin
               px_d = '0;
               py_d = py_q + P_W'(1);
               if (py_q == P_W'(PATCH - 1)) begin
                  py_d = '0;
                  pc_d = pc_q + PC_W'(1);
                  if (pc_q == PC_W'(COLS - 1)) begin
                     pc_d = '0;
                     pr_d = pr_q + PR_W'(1);
                     if (pr_q == PR_W'(ROWS - 1)) begin
                        pr_d = '0;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q  <= '0;
         px_q <= '0;
         py_q <= '0;
         pc_q <= '0;
         pr_q <= '0;
      end else begin
         c_q  <= c_d;
         px_q <= px_d;
         py_q <= py_d;
         pc_q <= pc_d;
         pr_q <= pr_d;
      end
   end

   assign t       = T_W'(int'(pr_q) * COLS + int'(pc_q));
   assign k       = K_W'((int'(py_q) * PATCH + int'(px_q)) * C + int'(c_q));
   assign pix_idx = PIX_W'(pix_index(int'(pr_q) * PATCH + int'(py_q),
                                     int'(pc_q) * PATCH + int'(px_q),
                                     int'(c_q), IMG_W, C));
   assign last_elem = (k == K_W'(PATCH_DIM - 1));

endmodule

// File: rtl/patch_extract.sv
// patch_extract: HWC image -> row-major stream of flattened PxPxC tokens plus a full flattened result bus.
// First element one cycle after start, done NUM_TOKENS*PATCH_DIM cycles later; s_ready low stalls all counters.
module patch_extract
   import patch_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int IMG_H      = 56,
   parameter  int IMG_W      = 56,
   parameter  int C          = 3,
   parameter  int PATCH      = 4,
   localparam int NUM_TOKENS = num_tokens(IMG_H, IMG_W, PATCH),
   localparam int PATCH_DIM  = patch_dim(PATCH, C),
   localparam int T_W        = cnt_width(NUM_TOKENS),
   localparam int IMG_BITS   = DATA_WIDTH * IMG_H * IMG_W * C,
   localparam int OUT_BITS   = DATA_WIDTH * NUM_TOKENS * PATCH_DIM
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IMG_BITS-1:0]   img_in,
   output logic [DATA_WIDTH-1:0] s_data,
   output logic [T_W-1:0]        s_token,
   output logic                  s_last,
   output logic                  s_valid,
   input  logic                  s_ready,
   output logic [OUT_BITS-1:0]   patches_out,
   output logic                  out_valid,
   output logic                  done
);

   localparam int K_W   = cnt_width(PATCH_DIM);
   localparam int PIX_W = cnt_width(IMG_H * IMG_W * C);

   state_t                state_q, state_d;
   logic [IMG_BITS-1:0]   img_q, img_d;
   logic [OUT_BITS-1:0]   buf_q, buf_d;
   logic [OUT_BITS-1:0]   patches_q, patches_d;

   logic                  clr;
   logic                  adv;
   logic [T_W-1:0]        t;
   logic [K_W-1:0]        k;
   logic [PIX_W-1:0]      pix_idx;
   logic                  last_elem;
   logic [DATA_WIDTH-1:0] elem;
   logic [31:0]           wr_idx;

   patch_addr_gen #(
      .IMG_H (IMG_H),
      .IMG_W (IMG_W),
      .C     (C),
      .PATCH (PATCH)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .clear     (clr),
      .advance   (adv),
      .t         (t),
      .k         (k),
      .pix_idx   (pix_idx),
      .last_elem (last_elem)
   );

   assign elem   = img_q[pix_idx * DATA_WIDTH +: DATA_WIDTH];
   assign wr_idx = 32'(t) * 32'(PATCH_DIM) + 32'(k);

   always_comb begin
      state_d   = state_q;
      img_d     = img_q;
      buf_d     = buf_q;
      patches_d = patches_q;
      clr       = 1'b0;
      adv       = 1'b0;
      s_valid   = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               img_d   = img_in;
               clr     = 1'b1;
               state_d = S_COPY;
            end
         end
         S_COPY: begin
            s_valid = 1'b1;
            if (s_ready) begin
               adv = 1'b1;
               buf_d[wr_idx * DATA_WIDTH +: DATA_WIDTH] = elem;
               // Publish on the final transfer so patches_out is already valid during the done pulse.
               if (last_elem && (t == T_W'(NUM_TOKENS - 1))) begin
                  patches_d = buf_d;
                  state_d   = S_DONE;
               end
            end
         end
         S_DONE: begin
            done      = 1'b1;
            out_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         img_q     <= '0;
         buf_q     <= '0;
         patches_q <= '0;
      end else begin
         state_q   <= state_d;
         img_q     <= img_d;
         buf_q     <= buf_d;
         patches_q <= patches_d;
      end
   end

   // Stream outputs read as zero whenever no element is being offered.
   assign s_data      = s_valid ? elem : '0;
   assign s_token     = s_valid ? t : '0;
   assign s_last      = s_valid & last_elem;
   assign patches_out = patches_q;

endmodule
